// File: rtl/router_fsm.sv
// Packet router control FSM: decodes the header address, sequences FIFO writes,
// stalls on full FIFOs and handles parity and per-FIFO timeout resets.
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StFifoFullState,
    StLoadAfterFull,
    StLoadParity,
    StCheckParityError,
    StWaitTillEmpty
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q;
  logic [1:0] sel;
  logic       empty_sel;
  logic       soft_sel;

  // The header byte selects the FIFO while decoding; the latched address afterwards.
  always_comb begin
    sel       = (state_q == StDecodeAddress) ? din : addr_q;
    empty_sel = 1'b0;
    soft_sel  = 1'b0;
    case (sel)
      2'd0: begin
        empty_sel = fifo_empty_0;
        soft_sel  = soft_reset_0;
      end
      2'd1: begin
        empty_sel = fifo_empty_1;
        soft_sel  = soft_reset_1;
      end
      2'd2: begin
        empty_sel = fifo_empty_2;
        soft_sel  = soft_reset_2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (soft_sel) begin
      state_d = StDecodeAddress;
    end else begin
      case (state_q)
        StDecodeAddress: begin
          if (pkt_valid && din != 2'd3) begin
            state_d = empty_sel ? StLoadFirstData : StWaitTillEmpty;
          end
        end
        StWaitTillEmpty: if (empty_sel) state_d = StLoadFirstData;
        StLoadFirstData: state_d = StLoadData;
        StLoadData: begin
          if (fifo_full)       state_d = StFifoFullState;
          else if (!pkt_valid) state_d = StLoadParity;
        end
        StFifoFullState: if (!fifo_full) state_d = StLoadAfterFull;
        StLoadAfterFull: begin
          if (parity_done)        state_d = StDecodeAddress;
          else if (low_pkt_valid) state_d = StLoadParity;
          else                    state_d = StLoadData;
        end
        StLoadParity:       state_d = StCheckParityError;
        StCheckParityError: state_d = fifo_full ? StFifoFullState : StDecodeAddress;
        default:            state_d = StDecodeAddress;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StDecodeAddress;
      addr_q        <= 2'd0;
      detect_addr   <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecodeAddress && pkt_valid) addr_q <= din;
      detect_addr   <= (state_d == StDecodeAddress);
      lfd_state     <= (state_d == StLoadFirstData);
      ld_state      <= (state_d == StLoadData);
      full_state    <= (state_d == StFifoFullState);
      laf_state     <= (state_d == StLoadAfterFull);
      rst_int_reg   <= (state_d == StCheckParityError);
      write_enb_reg <= (state_d == StLoadData) || (state_d == StLoadParity) ||
                       (state_d == StLoadAfterFull);
      busy          <= !((state_d == StDecodeAddress) || (state_d == StLoadData));
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios plus randomized traffic,
// compared every cycle against a named-state reference model.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] din = 2'd0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
  logic       rst_int_reg, write_enb_reg, busy;

  router_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .din           (din),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {detect_addr, lfd_state, ld_state, full_state, laf_state,
                 rst_int_reg, write_enb_reg, busy};

  int    n_checks = 0;
  int    n_pass   = 0;
  string ms       = "DA";  // model state name
  int    ma       = 0;     // model latched address

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected output vector for a named state.
  function automatic logic [7:0] exp_out(input string s);
    logic we, bsy;
    we  = (s == "LD") || (s == "LP") || (s == "LAF");
    bsy = !((s == "DA") || (s == "LD"));
    return {s == "DA", s == "LFD", s == "LD", s == "FF", s == "LAF", s == "CPE", we, bsy};
  endfunction

  function automatic string model_next();
    int   n;
    logic e, sr;
    n  = (ms == "DA") ? int'(din) : ma;
    e  = (n == 0) ? fifo_empty_0 : (n == 1) ? fifo_empty_1 : (n == 2) ? fifo_empty_2 : 1'b0;
    sr = (n == 0) ? soft_reset_0 : (n == 1) ? soft_reset_1 : (n == 2) ? soft_reset_2 : 1'b0;
    if (sr) return "DA";
    if (ms == "DA") begin
      if (pkt_valid && din != 2'd3) return e ? "LFD" : "WTE";
      return "DA";
    end
    if (ms == "WTE") return e ? "LFD" : "WTE";
    if (ms == "LFD") return "LD";
    if (ms == "LD")  return fifo_full ? "FF" : (!pkt_valid ? "LP" : "LD");
    if (ms == "FF")  return fifo_full ? "FF" : "LAF";
    if (ms == "LAF") return parity_done ? "DA" : (low_pkt_valid ? "LP" : "LD");
    if (ms == "LP")  return "CPE";
    if (ms == "CPE") return fifo_full ? "FF" : "DA";
    return "DA";
  endfunction

  task automatic cycle();
    string nxt;
    nxt = model_next();
    if (ms == "DA" && pkt_valid) ma = int'(din);
    @(posedge clk);
    #1;
    ms = nxt;
    check_eq({"state_", ms}, outs, exp_out(ms));
  endtask

  // Assert reset mid-cycle, check before the next edge, release away from an edge.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    ms = "DA";
    ma = 0;
    check_eq("async_rst", outs, exp_out("DA"));
    #3;
    rst = 1'b1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; din = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  // Header, first data, then n_ld cycles in LOAD_DATA with pkt_valid high.
  task automatic start_packet(input logic [1:0] a, input int n_ld);
    din = a;
    pkt_valid = 1'b1;
    cycle();
    cycle();
    for (int i = 1; i < n_ld; i++) cycle();
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_eq("reset", outs, exp_out("DA"));
    @(posedge clk); #1 check_eq("reset_hold", outs, exp_out("DA"));
    #3 rst = 1'b1;

    // Normal packet to FIFO 1.
    start_packet(2'd1, 3);
    pkt_valid = 1'b0;
    cycle(); cycle();
    check_eq("cpe_rst_int", outs, 8'b0000_0101);
    cycle();

    // Destination busy for 5 cycles.
    din = 2'd2; pkt_valid = 1'b1; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("wte_busy", {7'd0, busy}, 8'd1);
    fifo_empty_2 = 1'b1;
    cycle();
    check_eq("wte_to_lfd", outs, exp_out("LFD"));
    cycle();

    // Full stall, then resume into parity.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("ff_no_write", {7'd0, write_enb_reg}, 8'd0);
    fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    cycle();
    check_eq("laf_write", {7'd0, write_enb_reg}, 8'd1);
    cycle(); cycle(); cycle();
    low_pkt_valid = 1'b0;

    // LOAD_AFTER_FULL with parity already done.
    start_packet(2'd0, 1);
    fifo_full = 1'b1; cycle();
    fifo_full = 1'b0; cycle();
    parity_done = 1'b1; cycle();
    check_eq("laf_parity_done", outs, exp_out("DA"));
    parity_done = 1'b0;

    // Soft reset of another FIFO is ignored; of the selected FIFO aborts.
    start_packet(2'd0, 2);
    soft_reset_1 = 1'b1; cycle();
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; cycle();
    check_eq("soft_reset_0", outs, exp_out("DA"));
    soft_reset_0 = 1'b0;
    pkt_valid = 1'b0; cycle();

    // Async reset in FIFO_FULL_STATE, then an invalid header.
    start_packet(2'd2, 1);
    fifo_full = 1'b1; cycle();
    async_reset();
    fifo_full = 1'b0;
    din = 2'd3; pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    idle_inputs();
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      din           = 2'($urandom);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 9) < 7);
      fifo_empty_1  = ($urandom_range(0, 9) < 7);
      fifo_empty_2  = ($urandom_range(0, 9) < 7);
      soft_reset_0  = ($urandom_range(0, 29) == 0);
      soft_reset_1  = ($urandom_range(0, 29) == 0);
      soft_reset_2  = ($urandom_range(0, 29) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
